// File: rtl/instr_mem_axil_slave.sv
// Instruction memory: AXI4-Lite slave for host program load/readback plus an independent core fetch port.
// Latency: write AW+W cycle N -> BVALID N+1; read AR cycle N -> RVALID N+2; fetch data one cycle after fetch_en.
// Backpressure: BVALID/RVALID held stable until BREADY/RREADY; address/data readies drop while a response is pending.
module instr_mem_axil_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH          = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            fetch_en,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   fetch_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   fetch_data
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int MW = $clog2(MEM_DEPTH);

    localparam logic [DW-1:0] NOP_INSN  = DW'(32'h0000_0013);
    localparam logic [1:0]    RESP_OKAY = 2'b00;
    localparam logic [1:0]    RESP_SLV  = 2'b10;

    // Word storage; deliberately never cleared by reset so programs survive a core reset.
    logic [DW-1:0] mem [0:MEM_DEPTH-1];

    // Byte address -> in-range test on the word index (low two bits ignored).
    function automatic logic idx_ok(input logic [AW-1:0] a);
        return 32'(a[AW-1:2]) < 32'(MEM_DEPTH);
    endfunction

    // Byte address -> RAM row.
    function automatic logic [MW-1:0] midx(input logic [AW-1:0] a);
        return a[MW+1:2];
    endfunction

    // Protection bits carry no meaning for this memory.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic {W_IDLE, W_RESP} wstate_t;

    wstate_t        wstate, wstate_nxt;
    logic           aw_held, w_held;
    logic [AW-1:0]  awaddr_q;
    logic [DW-1:0]  wdata_q;
    logic [SW-1:0]  wstrb_q;
    logic [1:0]     bresp_q;
    logic           aw_fire, w_fire, wr_commit;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [SW-1:0]  wr_strb;

    // A held beat wins over the live bus; otherwise the beat arriving this cycle is used directly.
    assign wr_addr     = aw_held ? awaddr_q : S_AXI_AWADDR;
    assign wr_data     = w_held  ? wdata_q  : S_AXI_WDATA;
    assign wr_strb     = w_held  ? wstrb_q  : S_AXI_WSTRB;
    assign S_AXI_BRESP = bresp_q;

    // Write FSM next state, handshake readies and the commit strobe.
    always_comb begin
        wstate_nxt    = wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        aw_fire       = 1'b0;
        w_fire        = 1'b0;
        wr_commit     = 1'b0;
        case (wstate)
            W_IDLE: begin
                S_AXI_AWREADY = !aw_held;
                S_AXI_WREADY  = !w_held;
                aw_fire       = S_AXI_AWVALID && !aw_held;
                w_fire        = S_AXI_WVALID  && !w_held;
                wr_commit     = (aw_held || aw_fire) && (w_held || w_fire);
                if (wr_commit) begin
                    wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    wstate_nxt = W_IDLE;
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM state, per-channel held flags and the response code.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate  <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            wstate <= wstate_nxt;
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= idx_ok(wr_addr) ? RESP_OKAY : RESP_SLV;
            end else begin
                if (aw_fire) aw_held <= 1'b1;
                if (w_fire)  w_held  <= 1'b1;
            end
        end
    end

    // Payload capture for a beat that arrives before its partner; qualified by the held flags.
    always_ff @(posedge ACLK) begin
        if (aw_fire) begin
            awaddr_q <= S_AXI_AWADDR;
        end
        if (w_fire) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    // RAM byte-lane write; independent of reset so a commit coinciding with reset still lands.
    always_ff @(posedge ACLK) begin
        if (wr_commit && idx_ok(wr_addr)) begin
            for (int b = 0; b < SW; b++) begin
                if (wr_strb[b]) begin
                    mem[midx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP} rstate_t;

    rstate_t        rstate, rstate_nxt;
    logic [AW-1:0]  araddr_q;
    logic [DW-1:0]  rdata_q;
    logic [1:0]     rresp_q;

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

    // Read FSM next state and handshake signals.
    always_comb begin
        rstate_nxt    = rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rstate)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) begin
                    rstate_nxt = R_MEM;
                end
            end
            R_MEM: begin
                rstate_nxt = R_RESP;
            end
            R_RESP: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    rstate_nxt = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM state plus the registered RAM read; sampling old contents gives read-first ordering.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate  <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            rstate <= rstate_nxt;
            if (rstate == R_MEM) begin
                rdata_q <= idx_ok(araddr_q) ? mem[midx(araddr_q)] : '0;
                rresp_q <= idx_ok(araddr_q) ? RESP_OKAY : RESP_SLV;
            end
        end
    end

    // Read address capture on the AR handshake.
    always_ff @(posedge ACLK) begin
        if (rstate == R_IDLE && S_AXI_ARVALID) begin
            araddr_q <= S_AXI_ARADDR;
        end
    end

    // ------------------------------------------------------------------
    // Core fetch port: never stalled, holds its last word when idle.
    // ------------------------------------------------------------------

    // Registered fetch; out-of-range words read as a NOP so a runaway PC does no harm.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            fetch_data <= '0;
        end else if (fetch_en) begin
            fetch_data <= idx_ok(fetch_addr) ? mem[midx(fetch_addr)] : NOP_INSN;
        end
    end

endmodule

// File: tb/tb_instr_mem_axil_slave.sv
// Bench for instr_mem_axil_slave: directed scenarios plus randomized traffic against a word-array model.
// Latency: checks BVALID one cycle after the later of AW/W, RVALID two cycles after AR, fetch one cycle.
// Backpressure: holds BREADY/RREADY low for chosen cycles and checks response stability.
module tb_instr_mem_axil_slave;

    localparam int AW    = 13;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            areset;
    logic [AW-1:0]   awaddr, araddr, fetch_addr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, fetch_en;
    logic [31:0]     wdata, rdata, fetch_data;
    logic [3:0]      wstrb;
    logic [1:0]      bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mdl [0:DEPTH-1];

    always #5 clk = ~clk;

    // Cycle counter used to measure handshake-to-response latency.
    always @(posedge clk) cyc <= cyc + 1;

    instr_mem_axil_slave #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(32),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .ACLK(clk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data)
    );

    function automatic bit in_rng(input logic [AW-1:0] a);
        return int'(a >> 2) < DEPTH;
    endfunction

    function automatic logic [31:0] exp_read(input logic [AW-1:0] a);
        return in_rng(a) ? mdl[int'(a >> 2)] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_fetch(input logic [AW-1:0] a);
        return in_rng(a) ? mdl[int'(a >> 2)] : 32'h0000_0013;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
        return in_rng(a) ? 2'b00 : 2'b10;
    endfunction

    // Full write transaction; updates the model, returns BRESP, latency and a count of stability errors.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, input bit leave_b,
                             output logic [1:0] resp, output int lat, output int stab_err);
        int aw_c, w_c, t, idx;
        aw_c = -1; w_c = -1; t = 0; stab_err = 0;
        while ((aw_c < 0 || w_c < 0) && t < 64) begin
            @(negedge clk);
            awaddr  = a; wdata = d; wstrb = s;
            awvalid = (aw_c < 0) && (t >= aw_dly);
            wvalid  = (w_c < 0) && (t >= w_dly);
            #1;
            if (awvalid && awready) aw_c = cyc;
            if (wvalid && wready)   w_c  = cyc;
            t++;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; t = 0;
        while (!bvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        resp = bresp;
        lat  = (bvalid && aw_c >= 0 && w_c >= 0) ? cyc - ((aw_c > w_c) ? aw_c : w_c) : -1;
        if (in_rng(a)) begin
            idx = int'(a >> 2);
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        end
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            if (!bvalid || bresp !== resp || awready || wready) stab_err++;
        end
        if (!leave_b) begin
            bready = 1'b1;
            @(negedge clk);
            bready = 1'b0;
            if (bvalid) stab_err++;
        end
    endtask

    // Full read transaction; returns data, RRESP, latency and a count of stability errors.
    task automatic axi_read(input logic [AW-1:0] a, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output int stab_err);
        int ar_c, t;
        ar_c = -1; t = 0; stab_err = 0;
        while (ar_c < 0 && t < 64) begin
            @(negedge clk);
            araddr = a; arvalid = 1'b1;
            #1;
            if (arready) ar_c = cyc;
            t++;
        end
        @(negedge clk);
        arvalid = 1'b0; t = 0;
        while (!rvalid && t < 20) begin
            if (arready) stab_err++;
            @(negedge clk);
            t++;
        end
        data = rdata;
        resp = rresp;
        lat  = (rvalid && ar_c >= 0) ? cyc - ar_c : -1;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            if (!rvalid || rdata !== data || rresp !== resp || arready) stab_err++;
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        if (rvalid) stab_err++;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, output logic [31:0] data);
        @(negedge clk);
        fetch_en = 1'b1; fetch_addr = a;
        @(negedge clk);
        fetch_en = 1'b0;
        data = fetch_data;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00)
            begin n_fail++; $display("FAIL reset_ctrl bvalid=%b rvalid=%b bresp=%b rresp=%b exp 0", bvalid, rvalid, bresp, rresp); end
        n_checks++;
        if (rdata !== 32'h0 || fetch_data !== 32'h0)
            begin n_fail++; $display("FAIL reset_data rdata=%h fetch=%h exp 0", rdata, fetch_data); end
        areset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1)
            begin n_fail++; $display("FAIL idle_ready aw=%b w=%b ar=%b exp 111", awready, wready, arready); end
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [31:0] d; int lat, se;
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, 1'b0, r, lat, se);
            n_checks++;
            if (r !== 2'b00 || lat !== 1 || se !== 0)
                begin n_fail++; $display("FAIL basic_write%0d bresp=%b lat=%0d stab=%0d exp 00/1/0", i, r, lat, se); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(i * 4), 0, d, r, lat, se);
            n_checks++;
            if (d !== 32'(i + 1) || r !== 2'b00 || lat !== 2 || se !== 0)
                begin n_fail++; $display("FAIL basic_read%0d data=%h resp=%b lat=%0d stab=%0d exp %h/00/2/0", i, d, r, lat, se, i + 1); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [31:0] d; int lat, se;
        axi_write(AW'('h10), 32'hAABBCCDD, 4'hF, 0, 0, 0, 1'b0, r, lat, se);
        axi_write(AW'('h10), 32'h11223344, 4'b0101, 1, 0, 2, 1'b0, r, lat, se);
        n_checks++;
        if (r !== 2'b00 || lat !== 1 || se !== 0)
            begin n_fail++; $display("FAIL strobe_write bresp=%b lat=%0d stab=%0d exp 00/1/0", r, lat, se); end
        axi_read(AW'('h10), 0, d, r, lat, se);
        n_checks++;
        if (d !== 32'hAA22CC44)
            begin n_fail++; $display("FAIL strobe_read data=%h exp aa22cc44", d); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r; logic [31:0] d; int lat, se;
        axi_write(AW'('h20), 32'hDEADBEEF, 4'hF, 3, 0, 0, 1'b0, r, lat, se);
        n_checks++;
        if (r !== 2'b00 || lat !== 1 || se !== 0)
            begin n_fail++; $display("FAIL w_first_lat bresp=%b lat=%0d stab=%0d exp 00/1/0", r, lat, se); end
        axi_read(AW'('h20), 0, d, r, lat, se);
        n_checks++;
        if (d !== 32'hDEADBEEF)
            begin n_fail++; $display("FAIL w_first_read data=%h exp deadbeef", d); end
    endtask

    task automatic test_read_stall();
        logic [1:0] r; logic [31:0] d; int lat, se;
        axi_read(AW'(0), 5, d, r, lat, se);
        n_checks++;
        if (d !== exp_read(AW'(0)) || r !== 2'b00 || lat !== 2 || se !== 0)
            begin n_fail++; $display("FAIL read_stall data=%h resp=%b lat=%0d stab=%0d exp %h/00/2/0", d, r, lat, se, exp_read(AW'(0))); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r; logic [31:0] d; int lat, se;
        axi_write(AW'('h1000), 32'h12345678, 4'hF, 0, 0, 1, 1'b0, r, lat, se);
        n_checks++;
        if (r !== 2'b10 || lat !== 1 || se !== 0)
            begin n_fail++; $display("FAIL oor_write bresp=%b lat=%0d stab=%0d exp 10/1/0", r, lat, se); end
        axi_read(AW'('h1000), 1, d, r, lat, se);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b10 || se !== 0)
            begin n_fail++; $display("FAIL oor_read data=%h resp=%b stab=%0d exp 0/10/0", d, r, se); end
        do_fetch(AW'('h1000), d);
        n_checks++;
        if (d !== 32'h0000_0013)
            begin n_fail++; $display("FAIL oor_fetch data=%h exp 00000013", d); end
        axi_read(AW'(0), 0, d, r, lat, se);
        n_checks++;
        if (d !== 32'h1 || r !== 2'b00)
            begin n_fail++; $display("FAIL oor_preserve data=%h resp=%b exp 1/00", d, r); end
    endtask

    task automatic test_fetch();
        logic [31:0] d, held;
        do_fetch(AW'('h4), held);
        n_checks++;
        if (held !== exp_fetch(AW'('h4)))
            begin n_fail++; $display("FAIL fetch_word data=%h exp %h", held, exp_fetch(AW'('h4))); end
        @(negedge clk);
        fetch_addr = AW'('h20);
        @(negedge clk);
        d = fetch_data;
        n_checks++;
        if (d !== held)
            begin n_fail++; $display("FAIL fetch_hold data=%h exp %h", d, held); end
    endtask

    // Same-cycle write commit against the AXI read sample and the fetch sample of the same word.
    task automatic test_read_first();
        logic [31:0] old_v, nv;
        old_v = mdl[0];
        nv    = 32'hCAFE_0001;
        @(negedge clk);
        araddr = AW'(0); arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        awaddr = AW'(0); wdata = nv; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        fetch_en = 1'b1; fetch_addr = AW'(0);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; fetch_en = 1'b0;
        mdl[0] = nv;
        n_checks++;
        if (fetch_data !== old_v)
            begin n_fail++; $display("FAIL rf_fetch data=%h exp %h", fetch_data, old_v); end
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1)
            begin n_fail++; $display("FAIL rf_axi rvalid=%b rdata=%h bvalid=%b exp 1/%h/1", rvalid, rdata, bvalid, old_v); end
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        do_fetch(AW'(0), nv);
        n_checks++;
        if (nv !== mdl[0])
            begin n_fail++; $display("FAIL rf_after data=%h exp %h", nv, mdl[0]); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [31:0] d; int lat, se;
        axi_write(AW'('h8), 32'h5555_AAAA, 4'hF, 0, 0, 2, 1'b1, r, lat, se);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || bresp !== 2'b00)
            begin n_fail++; $display("FAIL rst_mid bvalid=%b bresp=%b exp 0/00", bvalid, bresp); end
        axi_write(AW'('h4), 32'h7777_0004, 4'hF, 0, 1, 0, 1'b0, r, lat, se);
        n_checks++;
        if (r !== 2'b00 || lat !== 1 || se !== 0)
            begin n_fail++; $display("FAIL rst_rewrite bresp=%b lat=%0d stab=%0d exp 00/1/0", r, lat, se); end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(i * 4), 0, d, r, lat, se);
            n_checks++;
            if (d !== mdl[i] || r !== 2'b00)
                begin n_fail++; $display("FAIL rst_keep%0d data=%h resp=%b exp %h/00", i, d, r, mdl[i]); end
        end
    endtask

    task automatic test_random();
        logic [1:0] r; logic [31:0] d; logic [AW-1:0] a; int lat, se;
        for (int i = 0; i < 64; i++)
            axi_write(AW'(i * 4), $urandom, 4'hF, 0, 0, 0, 1'b0, r, lat, se);
        for (int n = 0; n < 60; n++) begin
            a = AW'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | AW'('h1000);
            case ($urandom_range(0, 2))
                0: begin
                    axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 2), 1'b0, r, lat, se);
                    n_checks++;
                    if (r !== exp_resp(a) || lat !== 1 || se !== 0)
                        begin n_fail++; $display("FAIL rnd_write a=%h bresp=%b lat=%0d stab=%0d exp %b/1/0", a, r, lat, se, exp_resp(a)); end
                end
                1: begin
                    axi_read(a, $urandom_range(0, 3), d, r, lat, se);
                    n_checks++;
                    if (d !== exp_read(a) || r !== exp_resp(a) || lat !== 2 || se !== 0)
                        begin n_fail++; $display("FAIL rnd_read a=%h data=%h resp=%b lat=%0d stab=%0d exp %h/%b", a, d, r, lat, se, exp_read(a), exp_resp(a)); end
                end
                default: begin
                    do_fetch(a, d);
                    n_checks++;
                    if (d !== exp_fetch(a))
                        begin n_fail++; $display("FAIL rnd_fetch a=%h data=%h exp %h", a, d, exp_fetch(a)); end
                end
            endcase
        end
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        awaddr = '0; araddr = '0; fetch_addr = '0; awprot = 3'b0; arprot = 3'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        fetch_en = 1'b0; wdata = '0; wstrb = '0;
        test_reset();
        test_basic();
        test_strobe();
        test_w_before_aw();
        test_read_stall();
        test_out_of_range();
        test_fetch();
        test_read_first();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
